// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter: default widths,
// the owner state enum and the display saturation helper.
package seg_pkg;

  localparam int VAL_W_DEF   = 16;
  localparam int MAX_VAL_DEF = 9999;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Clamp a value to the largest number the four digits can show.
  function automatic logic [31:0] sat_value(input logic [31:0] value,
                                            input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search over requesters 1..N_REQ-1, starting at ptr
// and wrapping back to index 1.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:1] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:1] pick,
  output logic             found
);

  int idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 1;
    for (int o = 0; o < N_REQ - 1; o++) begin
      idx = ((int'(ptr) - 1 + o) % (N_REQ - 1)) + 1;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates ownership of the 4-digit display: urgent requester 0 preempts,
// the others rotate round-robin after a minimum dwell.
// Optional blinking of the urgent owner: define SEG_DISPLAY_ARBITER_BLINK_EN.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int VAL_W        = VAL_W_DEF,
  parameter int MAX_VAL      = MAX_VAL_DEF,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*VAL_W-1:0] req_value,
  output logic [N_REQ-1:0]       grant,
  output logic [VAL_W-1:0]       disp_value,
  output logic                   disp_blank,
  output logic                   switch_pulse
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int DW    = $clog2(HOLD_CYCLES);
  localparam logic [N_REQ-1:0] URGENT = N_REQ'(1);

  if (HOLD_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("seg_display_arbiter: HOLD_CYCLES must be >= 2 and BLINK_CYCLES >= 1");
  end

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt, arb;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [DW-1:0]      dwell;
  logic               dwell_done;
  logic [N_REQ-1:1]   masked, rr_hit;
  logic               rr_found;
  logic [VAL_W-1:0]   val_sel;
  logic               grant_change;

  // The current owner is masked out so rotation always lands on someone else.
  assign masked       = req[N_REQ-1:1] & ~grant[N_REQ-1:1];
  assign dwell_done   = (dwell == DW'(HOLD_CYCLES - 1));
  assign grant_change = (grant_nxt != grant);

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req   (masked),
    .ptr   (rr_ptr),
    .pick  (rr_hit),
    .found (rr_found)
  );

  always_comb begin
    arb = '0;
    if (req[0])        arb = URGENT;
    else if (rr_found) arb = {rr_hit, 1'b0};

    grant_nxt = grant;
    case (state)
      IDLE: grant_nxt = arb;
      OWNED: begin
        if (!(|(req & grant)))
          grant_nxt = arb;
        else if (req[0] && !grant[0])
          grant_nxt = URGENT;
        else if (!grant[0] && dwell_done && rr_found)
          grant_nxt = {rr_hit, 1'b0};
      end
      default: grant_nxt = '0;
    endcase
    state_nxt = (|grant_nxt) ? OWNED : IDLE;
  end

  // Owner's value and the pointer that resumes rotation just after the new owner.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    val_sel    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_nxt[k]) begin
        val_sel = req_value[k*VAL_W +: VAL_W];
        if (k != 0)
          rr_ptr_nxt = (k == N_REQ - 1) ? PTR_W'(1) : PTR_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= PTR_W'(1);
      dwell        <= '0;
      switch_pulse <= 1'b0;
      disp_value   <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      rr_ptr       <= rr_ptr_nxt;
      switch_pulse <= grant_change;
      if (grant_change)
        dwell <= '0;
      else if (state == OWNED && !dwell_done)
        dwell <= dwell + DW'(1);
      if (|grant_nxt)
        disp_value <= VAL_W'(sat_value(32'(val_sel), 32'(MAX_VAL)));
    end
  end

`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blank_r;

  // Urgent owner blinks starting from the shown phase; other owners stay lit.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blank_r   <= 1'b1;
    end else if (grant_change) begin
      blink_cnt <= '0;
      blank_r   <= ~|grant_nxt;
    end else if (grant_nxt[0]) begin
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        blank_r   <= ~blank_r;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blank_r <= ~|grant_nxt;
    end
  end

  assign disp_blank = blank_r;
`else
  assign disp_blank = ~|grant;
`endif

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios followed by
// random request traffic, all compared against an integer-level ownership model.
module tb_seg_display_arbiter;

  localparam int N     = 3;
  localparam int W     = 16;
  localparam int MAXV  = 9999;
  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_value;
  logic [N-1:0]   grant;
  logic [W-1:0]   disp_value;
  logic           disp_blank;
  logic           switch_pulse;

  int num_checks = 0;
  int num_fails  = 0;

  // Reference state: owner index (-1 when idle), dwell, next rotation start.
  int m_owner, m_dwell, m_ptr, m_value, m_pulse, m_blank, m_phase;
  int cur_val [N];

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .N_REQ(N), .VAL_W(W), .MAX_VAL(MAXV),
    .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_value    (req_value),
    .grant        (grant),
    .disp_value   (disp_value),
    .disp_blank   (disp_blank),
    .switch_pulse (switch_pulse)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rrSearch(input logic [N-1:0] r, input int ptr);
    int idx;
    for (int o = 0; o < N - 1; o++) begin
      idx = ((ptr - 1 + o) % (N - 1)) + 1;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_owner = -1; m_dwell = 0; m_ptr = 1; m_value = 0;
    m_pulse = 0;  m_blank = 1; m_phase = 0;
  endtask

  task automatic modelStep(input logic [N-1:0] r);
    int nw, t;
    logic [N-1:0] others;
    nw = m_owner;
    if (m_owner < 0 || !r[m_owner]) begin
      nw = r[0] ? 0 : rrSearch(r, m_ptr);
    end else if (r[0] && m_owner != 0) begin
      nw = 0;
    end else if (m_owner != 0 && m_dwell >= HOLD - 1) begin
      others = r;
      others[m_owner] = 1'b0;
      t = rrSearch(others, m_ptr);
      if (t >= 0) nw = t;
    end
    m_pulse = (nw != m_owner);
    if (m_pulse) begin
      m_dwell = 0;
      m_phase = 0;
      if (nw >= 1) m_ptr = (nw == N - 1) ? 1 : nw + 1;
    end else if (nw >= 0) begin
      m_dwell = (m_dwell + 1 > HOLD - 1) ? HOLD - 1 : m_dwell + 1;
      m_phase++;
    end
    m_owner = nw;
    if (nw >= 0) m_value = (cur_val[nw] > MAXV) ? MAXV : cur_val[nw];
`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
    m_blank = (nw < 0) ? 1 : (nw == 0) ? ((m_phase / BLINK) % 2) : 0;
`else
    m_blank = (nw < 0) ? 1 : 0;
`endif
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare after it.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] r,
                               input int v0, input int v1, input int v2);
    reset = rst;
    req   = r;
    cur_val[0] = v0; cur_val[1] = v1; cur_val[2] = v2;
    req_value = {W'(v2), W'(v1), W'(v0)};
    @(posedge clk);
    if (rst) modelReset();
    else     modelStep(r);
    #1;
    checkOutput("grant",        32'(grant),        (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    checkOutput("disp_value",   32'(disp_value),   32'(m_value));
    checkOutput("disp_blank",   32'(disp_blank),   32'(m_blank));
    checkOutput("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
  endtask

  logic [N-1:0] rq;
  logic         rst_i;
  int           vals [N];
  int           blink_exp [5];

  initial begin
    modelReset();
    reset = 1'b1; req = '0; req_value = '0;

    $display("[TB] reset");
    applyStimulus(1, 3'b000, 0, 0, 0);
    applyStimulus(1, 3'b000, 0, 0, 0);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_blank", 32'(disp_blank), 1);

    $display("[TB] first grant and rotation");
    applyStimulus(0, 3'b010, 0, 1234, 0);
    checkOutput("g1_grant", 32'(grant), 32'b010);
    checkOutput("g1_value", 32'(disp_value), 1234);
    checkOutput("g1_pulse", 32'(switch_pulse), 1);
    applyStimulus(0, 3'b010, 0, 1234, 555);
    checkOutput("g1_pulse_once", 32'(switch_pulse), 0);
    applyStimulus(0, 3'b110, 0, 1234, 555);
    applyStimulus(0, 3'b110, 0, 1234, 555);
    checkOutput("dwell_hold", 32'(grant), 32'b010);
    applyStimulus(0, 3'b110, 0, 1234, 555);
    checkOutput("rotate_grant", 32'(grant), 32'b100);
    checkOutput("rotate_pulse", 32'(switch_pulse), 1);
    applyStimulus(0, 3'b010, 0, 1234, 555);
    checkOutput("drop_back", 32'(grant), 32'b010);

    $display("[TB] urgent preemption");
    applyStimulus(0, 3'b100, 0, 1234, 555);
    applyStimulus(0, 3'b101, 42, 1234, 555);
    checkOutput("urgent_grant", 32'(grant), 32'b001);
    checkOutput("urgent_value", 32'(disp_value), 42);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 3'b111, 42, 1234, 555);
      checkOutput("urgent_keep", 32'(grant), 32'b001);
    end

    $display("[TB] saturation and live value");
    applyStimulus(0, 3'b010, 42, 12000, 555);
    checkOutput("sat_value", 32'(disp_value), 9999);
    applyStimulus(0, 3'b010, 42, 7, 555);
    checkOutput("live_value", 32'(disp_value), 7);
    checkOutput("live_no_pulse", 32'(switch_pulse), 0);

    $display("[TB] release and mid-dwell reset");
    applyStimulus(0, 3'b000, 42, 7, 555);
    checkOutput("idle_grant", 32'(grant), 0);
    checkOutput("idle_blank", 32'(disp_blank), 1);
    checkOutput("idle_hold", 32'(disp_value), 7);
    applyStimulus(0, 3'b100, 42, 7, 555);
    applyStimulus(0, 3'b100, 42, 7, 555);
    applyStimulus(0, 3'b100, 42, 7, 555);
    applyStimulus(1, 3'b100, 42, 7, 555);
    checkOutput("mid_rst_grant", 32'(grant), 0);
    checkOutput("mid_rst_value", 32'(disp_value), 0);
    checkOutput("mid_rst_blank", 32'(disp_blank), 1);

    $display("[TB] urgent owner blanking");
`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
    blink_exp = '{0, 0, 1, 1, 0};
`else
    blink_exp = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 3'b001, 3, 4, 5);
      checkOutput("blink_seq", 32'(disp_blank), 32'(blink_exp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 3'b010, 3, 4, 5);
      checkOutput("owner1_lit", 32'(disp_blank), 0);
    end

    $display("[TB] random traffic");
    rq = '0;
    for (int i = 0; i < N; i++) vals[i] = $urandom_range(0, 20000);
    for (int c = 0; c < 800; c++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      if ($urandom_range(0, 3) == 0) vals[$urandom_range(0, N - 1)] = $urandom_range(0, 20000);
      applyStimulus(rst_i, rq, vals[0], vals[1], vals[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
